// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller
// Double-buffered display value, dead-time blanking between digits, leading-zero blanking.
module disp_scan_ctrl #(
  parameter logic [15:0] SHOW_CYC  = 16'd50000,
  parameter logic [15:0] BLANK_CYC = 16'd500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] hex,
  input  logic [3:0]  points,
  input  logic [3:0]  les,
  input  logic        load,
  input  logic        lzb_en,
  output logic [3:0]  dec_d,
  output logic        dec_le,
  output logic        dec_point,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pend
);

  localparam logic        PH_BLANK   = 1'b0;
  localparam logic        PH_SHOW    = 1'b1;
  localparam logic        noBlank    = (BLANK_CYC == 16'd0);
  localparam logic        resetPhase = noBlank ? PH_SHOW : PH_BLANK;
  localparam logic [15:0] showLast   = SHOW_CYC - 16'd1;
  // Wraps to 16'hFFFF when BLANK_CYC is 0; the BLANK phase is never entered then.
  localparam logic [15:0] blankLast  = BLANK_CYC - 16'd1;

  logic        phaseQ, phaseD;
  logic [1:0]  digQ, digD;
  logic [15:0] cntQ, cntD;
  logic [15:0] actHexQ, actHexD;
  logic [3:0]  actPtQ, actPtD;
  logic [3:0]  actLeQ, actLeD;
  logic [15:0] pndHexQ, pndHexD;
  logic [3:0]  pndPtQ, pndPtD;
  logic [3:0]  pndLeQ, pndLeD;
  logic        pendQ, pendD;
  logic        frameEnd;
  logic        leadZero;
  logic [3:0]  nib;

  assign frameEnd = (phaseQ == PH_SHOW) && (digQ == 2'd3) && (cntQ == showLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phaseQ  <= resetPhase;
      digQ    <= 2'd0;
      cntQ    <= 16'd0;
      actHexQ <= 16'd0;
      actPtQ  <= 4'd0;
      actLeQ  <= 4'd0;
      pndHexQ <= 16'd0;
      pndPtQ  <= 4'd0;
      pndLeQ  <= 4'd0;
      pendQ   <= 1'b0;
    end else begin
      phaseQ  <= phaseD;
      digQ    <= digD;
      cntQ    <= cntD;
      actHexQ <= actHexD;
      actPtQ  <= actPtD;
      actLeQ  <= actLeD;
      pndHexQ <= pndHexD;
      pndPtQ  <= pndPtD;
      pndLeQ  <= pndLeD;
      pendQ   <= pendD;
    end
  end

  always_comb begin
    phaseD  = phaseQ;
    digD    = digQ;
    cntD    = cntQ;
    actHexD = actHexQ;
    actPtD  = actPtQ;
    actLeD  = actLeQ;
    pndHexD = pndHexQ;
    pndPtD  = pndPtQ;
    pndLeD  = pndLeQ;
    pendD   = pendQ;

    if (phaseQ == PH_BLANK) begin
      if (cntQ == blankLast) begin
        cntD   = 16'd0;
        phaseD = PH_SHOW;
      end else begin
        cntD = cntQ + 16'd1;
      end
    end else begin
      if (cntQ == showLast) begin
        cntD   = 16'd0;
        digD   = digQ + 2'd1;
        phaseD = noBlank ? PH_SHOW : PH_BLANK;
      end else begin
        cntD = cntQ + 16'd1;
      end
    end

    if (load) begin
      pndHexD = hex;
      pndPtD  = points;
      pndLeD  = les;
    end

    // Active buffers only change at the frame boundary so a frame is never mixed.
    if (frameEnd) begin
      if (load) begin
        actHexD = hex;
        actPtD  = points;
        actLeD  = les;
      end else if (pendQ) begin
        actHexD = pndHexQ;
        actPtD  = pndPtQ;
        actLeD  = pndLeQ;
      end
      pendD = 1'b0;
    end else if (load) begin
      pendD = 1'b1;
    end
  end

  always_comb begin
    nib = actHexQ[{digQ, 2'b00} +: 4];
    case (digQ)
      2'd3:    leadZero = (actHexQ[15:12] == 4'd0);
      2'd2:    leadZero = (actHexQ[15:8] == 8'd0);
      2'd1:    leadZero = (actHexQ[15:4] == 12'd0);
      default: leadZero = 1'b0;
    endcase

    dec_d      = nib;
    frame_done = frameEnd;
    pend       = pendQ;
    if (phaseQ == PH_BLANK) begin
      an        = 4'b1111;
      dec_le    = 1'b1;
      dec_point = 1'b0;
    end else begin
      an        = ~(4'b0001 << digQ);
      dec_le    = actLeQ[digQ] | (lzb_en & leadZero);
      dec_point = actPtQ[digQ];
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - directed self-checking bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] hex;
  logic [3:0]  points;
  logic [3:0]  les;
  logic        load;
  logic        lzb_en;
  logic [3:0]  dec_d, an;
  logic        dec_le, dec_point, frame_done, pend;
  logic [3:0]  decD2, an2;
  logic        decLe2, decPoint2, frameDone2, pend2;

  int total = 0;
  int bad   = 0;

  disp_scan_ctrl #(.SHOW_CYC(16'd4), .BLANK_CYC(16'd2)) dut (
    .clk(clk), .rst_n(rst_n), .hex(hex), .points(points), .les(les),
    .load(load), .lzb_en(lzb_en), .dec_d(dec_d), .dec_le(dec_le),
    .dec_point(dec_point), .an(an), .frame_done(frame_done), .pend(pend)
  );

  disp_scan_ctrl #(.SHOW_CYC(16'd1), .BLANK_CYC(16'd0)) dutNb (
    .clk(clk), .rst_n(rst_n), .hex(hex), .points(points), .les(les),
    .load(load), .lzb_en(lzb_en), .dec_d(decD2), .dec_le(decLe2),
    .dec_point(decPoint2), .an(an2), .frame_done(frameDone2), .pend(pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    load  = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b want=1111", an); end
    total++; if (dec_le !== 1'b1) begin bad++; $display("FAIL reset_le got=%b want=1", dec_le); end
    total++; if (dec_d !== 4'h0) begin bad++; $display("FAIL reset_d got=%h want=0", dec_d); end
    total++; if (dec_point !== 1'b0) begin bad++; $display("FAIL reset_pt got=%b want=0", dec_point); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b want=0", pend); end
    total++; if (decLe2 !== 1'b0) begin bad++; $display("FAIL reset_nb_le got=%b want=0", decLe2); end
  endtask

  task automatic test_idle_timing();
    logic [3:0] expAn;
    logic       expLe, expFd;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      int f, d, o;
      f = c % 24;
      d = f / 6;
      o = f % 6;
      expAn = (o < 2) ? 4'b1111 : ~(4'b0001 << d);
      expLe = (o < 2);
      expFd = (f == 23);
      total++; if (an !== expAn) begin bad++; $display("FAIL idle_an c=%0d got=%b want=%b", c, an, expAn); end
      total++; if (dec_le !== expLe) begin bad++; $display("FAIL idle_le c=%0d got=%b want=%b", c, dec_le, expLe); end
      total++; if (frame_done !== expFd) begin bad++; $display("FAIL idle_fd c=%0d got=%b want=%b", c, frame_done, expFd); end
      step(1);
    end
  endtask

  task automatic test_load();
    logic [3:0] expNib [4];
    logic       expPt  [4];
    expNib = '{4'hF, 4'h2, 4'hA, 4'h1};
    expPt  = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    step(3);
    hex = 16'h1A2F; points = 4'b0100; les = 4'b0000; load = 1'b1;
    step(1);
    load = 1'b0; hex = 16'h0; points = 4'h0;
    for (int c = 4; c < 48; c++) begin
      int f, d, o;
      f = c % 24;
      d = f / 6;
      o = f % 6;
      if (c <= 24) begin
        total++;
        if (pend !== (c < 24)) begin bad++; $display("FAIL load_pend c=%0d got=%b want=%b", c, pend, (c < 24)); end
      end
      if (o >= 2) begin
        if (c < 24) begin
          total++; if (dec_d !== 4'h0) begin bad++; $display("FAIL load_old c=%0d got=%h want=0", c, dec_d); end
        end else begin
          total++; if (dec_d !== expNib[d]) begin bad++; $display("FAIL load_d c=%0d got=%h want=%h", c, dec_d, expNib[d]); end
          total++; if (dec_point !== expPt[d]) begin bad++; $display("FAIL load_pt c=%0d got=%b want=%b", c, dec_point, expPt[d]); end
        end
      end
      step(1);
    end
  endtask

  task automatic test_lzb();
    logic [15:0] hexTab [3];
    logic [3:0]  lesTab [3];
    logic        lzbTab [3];
    logic [3:0]  expLe  [3];
    logic [15:0] h;
    logic [3:0]  expAn;
    hexTab = '{16'h0030, 16'h0000, 16'h0030};
    lesTab = '{4'b0000, 4'b0000, 4'b0010};
    lzbTab = '{1'b1, 1'b1, 1'b0};
    expLe  = '{4'b1100, 4'b1110, 4'b0010};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      hex = hexTab[s]; les = lesTab[s]; points = 4'b0000; lzb_en = lzbTab[s]; load = 1'b1;
      step(1);
      load = 1'b0;
      step(23);
      h = hexTab[s];
      for (int d = 0; d < 4; d++) begin
        step(2);
        expAn = ~(4'b0001 << d);
        total++; if (an !== expAn) begin bad++; $display("FAIL lzb_an s=%0d d=%0d got=%b want=%b", s, d, an, expAn); end
        total++; if (dec_le !== expLe[s][d]) begin bad++; $display("FAIL lzb_le s=%0d d=%0d got=%b want=%b", s, d, dec_le, expLe[s][d]); end
        total++; if (dec_d !== h[4*d +: 4]) begin bad++; $display("FAIL lzb_d s=%0d d=%0d got=%h want=%h", s, d, dec_d, h[4*d +: 4]); end
        step(4);
      end
    end
    lzb_en = 1'b0; les = 4'b0000; hex = 16'h0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    do_reset();
    step(23);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL b2b_fd got=%b want=1", frame_done); end
    hex = 16'hBEEF; points = 4'b0000; les = 4'b0000; load = 1'b1;
    step(1);
    load = 1'b0;
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL b2b_pend got=%b want=0", pend); end
    e = 16'hBEEF;
    for (int d = 0; d < 4; d++) begin
      step((d == 0) ? 2 : 6);
      total++; if (dec_d !== e[4*d +: 4]) begin bad++; $display("FAIL b2b_d d=%0d got=%h want=%h", d, dec_d, e[4*d +: 4]); end
    end
    hex = 16'h1234; load = 1'b1;
    step(1);
    total++; if (pend !== 1'b1) begin bad++; $display("FAIL b2b_pend1 got=%b want=1", pend); end
    hex = 16'h5678;
    step(1);
    load = 1'b0;
    total++; if (pend !== 1'b1) begin bad++; $display("FAIL b2b_pend2 got=%b want=1", pend); end
    step(2);
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL b2b_pend3 got=%b want=0", pend); end
    e = 16'h5678;
    for (int d = 0; d < 4; d++) begin
      step((d == 0) ? 2 : 6);
      total++; if (dec_d !== e[4*d +: 4]) begin bad++; $display("FAIL b2b_last d=%0d got=%h want=%h", d, dec_d, e[4*d +: 4]); end
    end
    hex = 16'h0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    hex = 16'h1A2F; load = 1'b1;
    step(1);
    load = 1'b0;
    step(36);
    hex = 16'h0; load = 1'b1;
    step(1);
    load = 1'b0;
    total++; if (an !== 4'b1011) begin bad++; $display("FAIL mid_an got=%b want=1011", an); end
    total++; if (dec_d !== 4'hA) begin bad++; $display("FAIL mid_d got=%h want=a", dec_d); end
    total++; if (pend !== 1'b1) begin bad++; $display("FAIL mid_pend got=%b want=1", pend); end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL rst_an got=%b want=1111", an); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL rst_pend got=%b want=0", pend); end
    total++; if (dec_le !== 1'b1) begin bad++; $display("FAIL rst_le got=%b want=1", dec_le); end
    step(2);
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL rst_an2 got=%b want=1110", an); end
    total++; if (dec_d !== 4'h0) begin bad++; $display("FAIL rst_d got=%h want=0", dec_d); end
    step(20);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd22 got=%b want=0", frame_done); end
    step(1);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL rst_fd23 got=%b want=1", frame_done); end
  endtask

  task automatic test_no_blank();
    logic [3:0] expAn;
    logic       expFd;
    hex = 16'h0; points = 4'h0; les = 4'h0; lzb_en = 1'b0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      expAn = ~(4'b0001 << (c % 4));
      expFd = ((c % 4) == 3);
      total++; if (an2 !== expAn) begin bad++; $display("FAIL nb_an c=%0d got=%b want=%b", c, an2, expAn); end
      total++; if (decLe2 !== 1'b0) begin bad++; $display("FAIL nb_le c=%0d got=%b want=0", c, decLe2); end
      total++; if (frameDone2 !== expFd) begin bad++; $display("FAIL nb_fd c=%0d got=%b want=%b", c, frameDone2, expFd); end
      step(1);
    end
  endtask

  initial begin
    rst_n = 1'b0; hex = 16'h0; points = 4'h0; les = 4'h0; load = 1'b0; lzb_en = 1'b0;
    step(2);
    test_reset();
    test_idle_timing();
    test_load();
    test_lzb();
    test_back_to_back();
    test_reset_midframe();
    test_no_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
